// File: rtl/centrosym_inverse.sv
`timescale 1ns/1ps
// centrosym_inverse
//
// Inverse of the unitary-ESPRIT centrosymmetric transform. Given the
// transformed-domain pair y1 = x1 + x2 and y2 = -j(x1 - x2), it recovers
//   x1 = (y1 + j*y2) / 2
//   x2 = (y1 - j*y2) / 2
// with round-half-up halving and saturation to DIN_WIDTH bits. The block is
// a 3-stage valid/ready pipeline (input register, sum register, output
// register) and never loses, duplicates or reorders a sample.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   y1_re..y2_im          : signed DIN_WIDTH+1 transformed-domain sample
//   din_valid / din_ready : input handshake (din_ready combinational from dout_ready)
//   x1_re..x2_im          : signed DIN_WIDTH recovered element-domain samples
//   dout_valid/dout_ready : output handshake
//   sat_clr               : synchronous clear of both sticky flags (a same-cycle set wins)
//   sat_flag              : sticky, some output component was clamped
//   parity_err            : sticky, some pre-halving sum was odd, i.e. the input
//                           was not the image of a forward transform
module centrosym_inverse #(
  parameter int DIN_WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH:0]   y1_re,
  input  logic signed [DIN_WIDTH:0]   y1_im,
  input  logic signed [DIN_WIDTH:0]   y2_re,
  input  logic signed [DIN_WIDTH:0]   y2_im,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic signed [DIN_WIDTH-1:0] x1_re,
  output logic signed [DIN_WIDTH-1:0] x1_im,
  output logic signed [DIN_WIDTH-1:0] x2_re,
  output logic signed [DIN_WIDTH-1:0] x2_im,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  input  logic                        sat_clr,
  output logic                        sat_flag,
  output logic                        parity_err
);

  localparam int YW = DIN_WIDTH + 1;  // input width
  localparam int SW = DIN_WIDTH + 2;  // sum width, also used for the halved value

  localparam logic signed [SW-1:0] X_MAX = SW'((2 ** (DIN_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] X_MIN = ~X_MAX;

  function automatic logic signed [SW-1:0] sext(input logic signed [YW-1:0] v);
    return {v[YW-1], v};
  endfunction

  // (s + 1) >>> 1 evaluated one bit wider so the +1 can never wrap; the
  // halved value of a full-scale sum needs SW bits before clamping.
  function automatic logic signed [SW-1:0] round_half(input logic signed [SW-1:0] s);
    logic signed [SW:0] t;
    t = {s[SW-1], s};
    t = t + {{SW{1'b0}}, 1'b1};
    return SW'(t >>> 1);
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] h);
    return (h > X_MAX) || (h < X_MIN);
  endfunction

  function automatic logic signed [DIN_WIDTH-1:0] saturate(input logic signed [SW-1:0] h);
    if (h > X_MAX) return X_MAX[DIN_WIDTH-1:0];
    if (h < X_MIN) return X_MIN[DIN_WIDTH-1:0];
    return h[DIN_WIDTH-1:0];
  endfunction

  // Stage valids and load enables. A stage advances when it is empty or
  // when the stage after it advances, so a full pipeline moves as a unit.
  logic vld_p0, vld_p1, vld_p2;
  logic ld_p0, ld_p1, ld_p2;
  logic xfer_p2;

  assign ld_p2      = !vld_p2 || dout_ready;
  assign ld_p1      = !vld_p1 || ld_p2;
  assign ld_p0      = !vld_p0 || ld_p1;
  assign xfer_p2    = ld_p2 && vld_p1;
  assign din_ready  = ld_p0;
  assign dout_valid = vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= din_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: input capture ----
  logic signed [YW-1:0] y1_re_p0, y1_im_p0, y2_re_p0, y2_im_p0;

  always_ff @(posedge clk) begin
    if (ld_p0 && din_valid) begin
      y1_re_p0 <= y1_re;
      y1_im_p0 <= y1_im;
      y2_re_p0 <= y2_re;
      y2_im_p0 <= y2_im;
    end
  end

  // ---- Stage 2: pre-halving sums and their parity ----
  // j*y2 = (-y2_im, y2_re), hence the cross-wired real/imag terms.
  logic signed [SW-1:0] s1r_c, s1i_c, s2r_c, s2i_c;
  logic signed [SW-1:0] s1r_p1, s1i_p1, s2r_p1, s2i_p1;
  logic                 par_c, par_p1;

  always_comb begin
    s1r_c = sext(y1_re_p0) - sext(y2_im_p0);
    s1i_c = sext(y1_im_p0) + sext(y2_re_p0);
    s2r_c = sext(y1_re_p0) + sext(y2_im_p0);
    s2i_c = sext(y1_im_p0) - sext(y2_re_p0);
    par_c = s1r_c[0] | s1i_c[0] | s2r_c[0] | s2i_c[0];
  end

  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      s1r_p1 <= s1r_c;
      s1i_p1 <= s1i_c;
      s2r_p1 <= s2r_c;
      s2i_p1 <= s2i_c;
      par_p1 <= par_c;
    end
  end

  // ---- Stage 3: rounding, saturation, output register and sticky flags ----
  logic signed [SW-1:0] h1r_c, h1i_c, h2r_c, h2i_c;
  logic                 sat_c;

  always_comb begin
    h1r_c = round_half(s1r_p1);
    h1i_c = round_half(s1i_p1);
    h2r_c = round_half(s2r_p1);
    h2i_c = round_half(s2i_p1);
    sat_c = clips(h1r_c) | clips(h1i_c) | clips(h2r_c) | clips(h2i_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_re <= '0;
      x1_im <= '0;
      x2_re <= '0;
      x2_im <= '0;
    end else if (xfer_p2) begin
      x1_re <= saturate(h1r_c);
      x1_im <= saturate(h1i_c);
      x2_re <= saturate(h2r_c);
      x2_im <= saturate(h2i_c);
    end
  end

  // Clear first, then OR in this cycle's event, so a coincident set survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sat_flag   <= (sat_flag   && !sat_clr) || (xfer_p2 && sat_c);
      parity_err <= (parity_err && !sat_clr) || (xfer_p2 && par_p1);
    end
  end

endmodule

// File: tb/tb_centrosym_inverse.sv
`timescale 1ns/1ps
module tb_centrosym_inverse;

  localparam int W    = 18;
  localparam int XMAX = (2 ** (W - 1)) - 1;
  localparam int XMIN = -(2 ** (W - 1));
  localparam int YMAX = (2 ** W) - 1;
  localparam int YMIN = -(2 ** W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W:0]   y1_re, y1_im, y2_re, y2_im;
  logic                din_valid, din_ready;
  logic signed [W-1:0] x1_re, x1_im, x2_re, x2_im;
  logic                dout_valid, dout_ready;
  logic                sat_clr, sat_flag, parity_err;

  centrosym_inverse #(.DIN_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .y1_re(y1_re), .y1_im(y1_im), .y2_re(y2_re), .y2_im(y2_im),
    .din_valid(din_valid), .din_ready(din_ready),
    .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sat_clr(sat_clr), .sat_flag(sat_flag), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x1r, x1i, x2r, x2i;
    bit sat, par;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   acc_sat, acc_par, sup;
  bit   rnd_done;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: complex arithmetic on plain integers, exact halving rounded
  // half toward +inf, then clamp to the DIN_WIDTH range.
  function automatic exp_t model(input int a, input int b, input int c, input int d);
    int s[4];
    int r[4];
    exp_t e;
    // x1 = y1 + j*y2, x2 = y1 - j*y2 (before halving); j*y2 = (-d, c)
    s[0] = a - d; s[1] = b + c;
    s[2] = a + d; s[3] = b - c;
    e.sat = 0; e.par = 0;
    for (int i = 0; i < 4; i++) begin
      r[i] = int'($floor(real'(s[i]) / 2.0 + 0.5));
      if (r[i] > XMAX) begin r[i] = XMAX; e.sat = 1; end
      else if (r[i] < XMIN) begin r[i] = XMIN; e.sat = 1; end
      if (s[i] % 2 != 0) e.par = 1;
    end
    e.x1r = r[0]; e.x1i = r[1]; e.x2r = r[2]; e.x2i = r[3];
    return e;
  endfunction

  task automatic send(input int a, input int b, input int c, input int d);
    int  t;
    bit  done;
    t = 0; done = 0;
    y1_re = (W+1)'(a); y1_im = (W+1)'(b); y2_re = (W+1)'(c); y2_im = (W+1)'(d);
    din_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (din_ready) begin
        sb.push_back(model(a, b, c, d));
        done = 1;
      end else if (++t > 1000) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: din_ready stuck at 0, expected 1 within 1000 cycles");
        done = 1;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    dout_ready = 1'b1;
    while (sb.size() != 0 || dout_valid) begin
      @(posedge clk); #1;
      if (++t > 100) begin
        n_vec++; n_err++;
        $display("FAIL drain_timeout: %0d samples still pending, expected 0", sb.size());
        sb.delete();
        break;
      end
    end
  endtask

  // Call right after send() returns on an empty pipeline.
  task automatic latency(input string tag);
    @(negedge clk); check({tag, "_lat_edge1"}, int'(dout_valid), 0);
    @(negedge clk); check({tag, "_lat_edge2"}, int'(dout_valid), 0);
    @(negedge clk); check({tag, "_lat_edge3"}, int'(dout_valid), 1);
  endtask

  function automatic int rnd_y();
    logic signed [W:0] v;
    case ($urandom_range(0, 5))
      0: return YMAX;
      1: return YMIN;
      default: begin
        v = (W+1)'($urandom);
        return int'(v);
      end
    endcase
  endfunction

  // Monitor: checks the presented sample every cycle (so a stalled output
  // must stay stable), pops on transfer, and tracks the sticky flags.
  exp_t mon_e;
  bit   mon_es, mon_ep;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      acc_sat = 0; acc_par = 0; sup = 0;
    end else begin
      mon_es = acc_sat; mon_ep = acc_par;
      if (dout_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: dout_valid=1 with no sample outstanding, expected 0");
        end else begin
          mon_e = sb[0];
          check("x1_re", int'(x1_re), mon_e.x1r);
          check("x1_im", int'(x1_im), mon_e.x1i);
          check("x2_re", int'(x2_re), mon_e.x2r);
          check("x2_im", int'(x2_im), mon_e.x2i);
          if (!sup) begin
            mon_es = mon_es | mon_e.sat;
            mon_ep = mon_ep | mon_e.par;
          end
        end
      end
      check("sat_flag", int'(sat_flag), int'(mon_es));
      check("parity_err", int'(parity_err), int'(mon_ep));
      if (sat_clr) begin
        acc_sat = 0; acc_par = 0;
        // a sample held at the output loses its flag contribution
        sup = dout_valid && !dout_ready;
        if (dout_valid && dout_ready && sb.size() != 0) void'(sb.pop_front());
      end else if (dout_valid && dout_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        if (!sup) begin
          acc_sat = acc_sat | mon_e.sat;
          acc_par = acc_par | mon_e.par;
        end
        sup = 0;
      end
    end
  end

  initial begin
    din_valid = 0; dout_ready = 1; sat_clr = 0;
    y1_re = '0; y1_im = '0; y2_re = '0; y2_im = '0;
    rnd_done = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_x1_re", int'(x1_re), 0);
    check("rst_x2_im", int'(x2_im), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_parity_err", int'(parity_err), 0);
    rst = 1'b0;
    #1;
    check("rst_din_ready", int'(din_ready), 1);
    @(posedge clk); #1;

    // Round trip: x1 = (100,-20), x2 = (200,-30)
    send(300, -50, 10, 100);
    latency("roundtrip");
    drain();
    check("roundtrip_parity", int'(parity_err), 0);
    check("roundtrip_sat", int'(sat_flag), 0);

    // Rounding: x1 = x2 = (2,-1), odd sums
    send(3, -3, 0, 0);
    drain();
    check("rounding_parity", int'(parity_err), 1);
    check("rounding_sat", int'(sat_flag), 0);

    // Saturation: x1_re clamps to 131071, x2_re = 0
    send(YMAX, 0, 0, YMIN);
    drain();
    check("saturate_sat", int'(sat_flag), 1);
    check("saturate_parity", int'(parity_err), 1);

    // One-cycle clear with a clean sample following
    sat_clr = 1'b1;
    send(2, 4, 6, 8);
    sat_clr = 1'b0;
    drain();
    check("clear_sat", int'(sat_flag), 0);
    check("clear_parity", int'(parity_err), 0);

    // Clear in the same cycle a saturating sample enters the output stage
    send(YMAX, 0, 0, YMIN);
    @(posedge clk); #1; sat_clr = 1'b1;
    @(posedge clk); #1; sat_clr = 1'b0;
    check("clrset_dout_valid", int'(dout_valid), 1);
    check("clrset_sat", int'(sat_flag), 1);
    drain();

    // Backpressure: 8-sample ramp, output stalled for 5 cycles mid-stream
    fork
      begin
        for (int i = 1; i <= 8; i++) send(4 * i, -4 * i, 2 * i, 6);
      end
      begin
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_din_ready_full", int'(din_ready), 0);
        check("bp_dout_valid_held", int'(dout_valid), 1);
        repeat (3) @(posedge clk);
        #1 dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_resume_dout_valid", int'(dout_valid), 1);
          check("bp_resume_din_ready", int'(din_ready), 1);
        end
      end
    join
    drain();

    // Reset mid-stream with 3 saturating samples in flight
    send(YMAX, 0, 0, YMIN);
    send(YMAX - 2, 0, 0, YMIN);
    send(YMAX - 4, 0, 0, YMIN);
    rst = 1'b1;
    #1;
    check("midrst_dout_valid", int'(dout_valid), 0);
    check("midrst_sat", int'(sat_flag), 0);
    check("midrst_parity", int'(parity_err), 0);
    check("midrst_x1_re", int'(x1_re), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    send(5, 7, -9, 11);
    latency("postrst");
    drain();

    // Randomized traffic with random backpressure and random clears
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(rnd_y(), rnd_y(), rnd_y(), rnd_y());
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          dout_ready = ($urandom_range(0, 3) != 0);
          sat_clr    = ($urandom_range(0, 15) == 0);
        end
      end
    join
    sat_clr = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
